// File: rtl/button_onehot_capture_if.sv
// Button capture bundle: raw button lines in, qualified one-hot code and strobes out.
interface button_onehot_capture_if;
  logic [3:0] btn_raw;
  logic [3:0] onehot;
  logic       valid;
  logic       multi_err;
  logic       busy;

  modport master (
    output btn_raw,
    input  onehot,
    input  valid,
    input  multi_err,
    input  busy
  );

  modport slave (
    input  btn_raw,
    output onehot,
    output valid,
    output multi_err,
    output busy
  );
endinterface

// File: rtl/button_onehot_capture.sv
// Synchronises and debounces four push buttons, then qualifies a single press into a
// registered, always-one-hot code with a valid strobe; multi-button presses pulse multi_err.
module button_onehot_capture #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  button_onehot_capture_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HOLD, LOCKOUT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       s1, s2, db;
  logic [CNT_W-1:0] cnt [4];

  state_t     state_q, state_d;
  logic [3:0] onehot_q, onehot_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       busy_q;
  logic       single;

  // Stage: two-flop synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn_raw;
      s2 <= s1;
    end
  end

  // Stage: per-bit debounce; db flips on the DEBOUNCE_CYCLES-th consecutive differing sample
  always_ff @(posedge clk) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign single = (db != 4'd0) && ((db & (db - 4'd1)) == 4'd0);

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (single) begin
          onehot_d = db;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end else if (db != 4'd0) begin
          err_d   = 1'b1;
          state_d = LOCKOUT;
        end
      end
      HOLD, LOCKOUT: begin
        if (db == 4'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage: registered qualification outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      onehot_q <= 4'b0001;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign bus.onehot    = onehot_q;
  assign bus.valid     = valid_q;
  assign bus.multi_err = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_button_onehot_capture.sv
// Directed bench for button_onehot_capture: table of hold phases plus exact-latency and reset sequences.
module tb_button_onehot_capture;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  button_onehot_capture_if bif ();

  button_onehot_capture #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    logic [3:0] btn;
    int         cycles;
    int         exp_valid;
    int         exp_err;
    logic [3:0] exp_onehot;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [18];
  int   vcnt, ecnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge, with invariants checked each cycle.
  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot_legal", 32'($countones(bif.onehot)), 32'd1);
    chk("valid_err_excl", 32'(bif.valid & bif.multi_err), 32'd0);
    if (bif.valid) vcnt++;
    if (bif.multi_err) ecnt++;
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 20, 0, 0, 4'b0001, 1'b0};
    vecs[1]  = '{4'b0100, 20, 1, 0, 4'b0100, 1'b1};
    vecs[2]  = '{4'b0000, 20, 0, 0, 4'b0100, 1'b0};
    vecs[3]  = '{4'b0010,  3, 0, 0, 4'b0100, 1'b0};
    vecs[4]  = '{4'b0000, 10, 0, 0, 4'b0100, 1'b0};
    vecs[5]  = '{4'b0010,  4, 0, 0, 4'b0100, 1'b0};
    vecs[6]  = '{4'b0000, 20, 1, 0, 4'b0010, 1'b0};
    vecs[7]  = '{4'b0011, 20, 0, 1, 4'b0010, 1'b1};
    vecs[8]  = '{4'b0000, 20, 0, 0, 4'b0010, 1'b0};
    vecs[9]  = '{4'b1000, 20, 1, 0, 4'b1000, 1'b1};
    vecs[10] = '{4'b0000, 20, 0, 0, 4'b1000, 1'b0};
    vecs[11] = '{4'b0001, 20, 1, 0, 4'b0001, 1'b1};
    vecs[12] = '{4'b1001, 20, 0, 0, 4'b0001, 1'b1};
    vecs[13] = '{4'b0000, 20, 0, 0, 4'b0001, 1'b0};
    vecs[14] = '{4'b1000, 20, 1, 0, 4'b1000, 1'b1};
    vecs[15] = '{4'b0000, 20, 0, 0, 4'b1000, 1'b0};
    vecs[16] = '{4'b1000, 20, 1, 0, 4'b1000, 1'b1};
    vecs[17] = '{4'b0000, 20, 0, 0, 4'b1000, 1'b0};

    bif.btn_raw = 4'b0000;
    reset = 1'b1;
    vcnt = 0;
    ecnt = 0;
    step();
    step();
    chk("rst_onehot", 32'(bif.onehot), 32'h1);
    chk("rst_valid", 32'(bif.valid), 32'd0);
    chk("rst_err", 32'(bif.multi_err), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 18; k++) begin
      vcnt = 0;
      ecnt = 0;
      bif.btn_raw = vecs[k].btn;
      for (int c = 0; c < vecs[k].cycles; c++) step();
      chk($sformatf("row%0d_valid_cnt", k), 32'(vcnt), 32'(vecs[k].exp_valid));
      chk($sformatf("row%0d_err_cnt", k), 32'(ecnt), 32'(vecs[k].exp_err));
      chk($sformatf("row%0d_onehot", k), 32'(bif.onehot), 32'(vecs[k].exp_onehot));
      chk($sformatf("row%0d_busy", k), 32'(bif.busy), 32'(vecs[k].exp_busy));
    end

    // Exact press latency: valid on the 7th edge after the change, for one cycle only.
    bif.btn_raw = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("lat_valid_e%0d", c), 32'(bif.valid), 32'd0);
    end
    step();
    chk("lat_valid_e7", 32'(bif.valid), 32'd1);
    chk("lat_onehot_e7", 32'(bif.onehot), 32'h4);
    chk("lat_busy_e7", 32'(bif.busy), 32'd1);
    step();
    chk("lat_valid_e8", 32'(bif.valid), 32'd0);

    // Exact release latency: busy falls 7 edges after release.
    bif.btn_raw = 4'b0000;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("rel_busy_e%0d", c), 32'(bif.busy), 32'd1);
    end
    step();
    chk("rel_busy_e7", 32'(bif.busy), 32'd0);
    chk("rel_onehot", 32'(bif.onehot), 32'h4);
    for (int c = 0; c < 5; c++) step();

    // Reset while holding a button in HOLD, then re-debounce after reset.
    bif.btn_raw = 4'b0100;
    for (int c = 0; c < 10; c++) step();
    chk("pre_rst_busy", 32'(bif.busy), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_onehot", 32'(bif.onehot), 32'h1);
    chk("mid_rst_busy", 32'(bif.busy), 32'd0);
    chk("mid_rst_valid", 32'(bif.valid), 32'd0);
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("post_rst_valid_e%0d", c), 32'(bif.valid), 32'd0);
    end
    step();
    chk("post_rst_valid_e7", 32'(bif.valid), 32'd1);
    chk("post_rst_onehot_e7", 32'(bif.onehot), 32'h4);
    step();
    chk("post_rst_valid_e8", 32'(bif.valid), 32'd0);

    bif.btn_raw = 4'b0000;
    for (int c = 0; c < 10; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
